// File: rtl/regfile_exec_ctrl_pkg.sv
// Shared definitions for the register-file execution controller: default
// widths, opcode encodings, FSM state encoding and status-flag bit positions.
// Decode and the register file reuse these.
package regfile_exec_ctrl_pkg;

    localparam int unsigned DataW = 16;
    localparam int unsigned AddrW = 4;
    localparam int unsigned ImmW  = 8;

    localparam logic [3:0] OpAdd = 4'd0;
    localparam logic [3:0] OpSub = 4'd1;
    localparam logic [3:0] OpAnd = 4'd2;
    localparam logic [3:0] OpOr  = 4'd3;
    localparam logic [3:0] OpXor = 4'd4;
    localparam logic [3:0] OpMov = 4'd5;
    localparam logic [3:0] OpCmp = 4'd6;
    localparam logic [3:0] OpLsh = 4'd7;

    // Flags vector is {C,F,Z,N}
    localparam int unsigned FlagC = 3;
    localparam int unsigned FlagF = 2;
    localparam int unsigned FlagZ = 1;
    localparam int unsigned FlagN = 0;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StExec,
        StWrite
    } state_e;

    // Opcodes 8..15 are reserved
    function automatic logic is_reserved(logic [3:0] op);
        return op[3];
    endfunction

endpackage

// File: rtl/regfile_exec_ctrl_if.sv
// Instruction handshake plus register-file port bundle.
//   master: the execution controller (consumes instructions, drives the
//           register-file address/enable/load lines).
//   slave : decode + register file side.
interface regfile_exec_ctrl_if
    import regfile_exec_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DataW,
    parameter int unsigned ADDR_W = AddrW,
    parameter int unsigned IMM_W  = ImmW
) ();

    logic              InstrValid;
    logic              InstrReady;
    logic [3:0]        Opcode;
    logic              UseImm;
    logic [ADDR_W-1:0] Dest;
    logic [ADDR_W-1:0] Src;
    logic [IMM_W-1:0]  Imm;
    logic [ADDR_W-1:0] RdestRegLoc;
    logic [ADDR_W-1:0] RsrcRegLoc;
    logic [DATA_W-1:0] RdestOut;
    logic [DATA_W-1:0] RsrcOut;
    logic              RfEn;
    logic [DATA_W-1:0] RfLoad;

    modport master (
        input  InstrValid, Opcode, UseImm, Dest, Src, Imm, RdestOut, RsrcOut,
        output InstrReady, RdestRegLoc, RsrcRegLoc, RfEn, RfLoad
    );

    modport slave (
        output InstrValid, Opcode, UseImm, Dest, Src, Imm, RdestOut, RsrcOut,
        input  InstrReady, RdestRegLoc, RsrcRegLoc, RfEn, RfLoad
    );

endinterface

// File: rtl/regfile_exec_ctrl_alu16.sv
// Combinational 16-bit ALU.
//   a, b    : operands
//   opcode  : operation select
//   result  : truncated result
//   carry   : carry out (ADD) or borrow (SUB/CMP)
//   ovf     : signed overflow (ADD/SUB/CMP)
//   illegal : reserved opcode
module regfile_exec_ctrl_alu16
    import regfile_exec_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DataW
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        opcode,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              ovf,
    output logic              illegal
);

    localparam int unsigned Msb = DATA_W - 1;

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        result  = '0;
        carry   = 1'b0;
        ovf     = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OpAdd: begin
                result = sum[Msb:0];
                carry  = sum[DATA_W];
                ovf    = (a[Msb] == b[Msb]) && (sum[Msb] != a[Msb]);
            end
            OpSub, OpCmp: begin
                result = diff[Msb:0];
                carry  = diff[DATA_W];  // borrow: a < b unsigned
                ovf    = (a[Msb] != b[Msb]) && (diff[Msb] != a[Msb]);
            end
            OpAnd:   result = a & b;
            OpOr:    result = a | b;
            OpXor:   result = a ^ b;
            OpMov:   result = b;
            OpLsh:   result = a << b[3:0];
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/regfile_exec_ctrl.sv
// Register-file execution controller. Accepts one decoded instruction per
// handshake, reads both operands, runs the ALU and writes the result back.
//   Clk, Rst  : clock, synchronous active-low reset
//   bus       : instruction handshake + register-file port (master side)
//   Flags     : {C,F,Z,N} status, updated when the instruction retires
//   Done      : one-cycle retire pulse (WRITE state)
//   IllegalOp : pulses with Done for reserved opcodes
module regfile_exec_ctrl
    import regfile_exec_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DataW,
    parameter int unsigned ADDR_W = AddrW,
    parameter int unsigned IMM_W  = ImmW
) (
    input  logic               Clk,
    input  logic               Rst,
    regfile_exec_ctrl_if.master bus,
    output logic [3:0]         Flags,
    output logic               Done,
    output logic               IllegalOp
);

    state_e            state_q;
    logic [3:0]        op_q;
    logic              use_imm_q;
    logic [IMM_W-1:0]  imm_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] result_q;
    logic [3:0]        flags_q;
    logic [3:0]        flags_pend_q;
    logic              ready_q;
    logic              rf_en_q;
    logic              done_q;
    logic              illegal_q;
    logic [ADDR_W-1:0] rdest_loc_q;
    logic [ADDR_W-1:0] rsrc_loc_q;

    logic [DATA_W-1:0] b_sel;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_ovf;
    logic              alu_illegal;
    logic [3:0]        flags_nxt;

    assign b_sel = use_imm_q ? {{(DATA_W-IMM_W){imm_q[IMM_W-1]}}, imm_q} : bus.RsrcOut;

    regfile_exec_ctrl_alu16 #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a       (a_q),
        .b       (b_q),
        .opcode  (op_q),
        .result  (alu_result),
        .carry   (alu_carry),
        .ovf     (alu_ovf),
        .illegal (alu_illegal)
    );

    // Flags staged in EXEC, committed on the WRITE exit edge
    always_comb begin
        flags_nxt = flags_q;
        case (op_q)
            OpAdd, OpSub, OpCmp: begin
                flags_nxt[FlagC] = alu_carry;
                flags_nxt[FlagF] = alu_ovf;
                flags_nxt[FlagZ] = (alu_result == '0);
                flags_nxt[FlagN] = alu_result[DATA_W-1];
            end
            OpAnd, OpOr, OpXor, OpLsh: begin
                flags_nxt[FlagZ] = (alu_result == '0);
                flags_nxt[FlagN] = alu_result[DATA_W-1];
            end
            default: flags_nxt = flags_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q      <= StIdle;
            op_q         <= '0;
            use_imm_q    <= 1'b0;
            imm_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            flags_q      <= '0;
            flags_pend_q <= '0;
            ready_q      <= 1'b1;
            rf_en_q      <= 1'b0;
            done_q       <= 1'b0;
            illegal_q    <= 1'b0;
            rdest_loc_q  <= '0;
            rsrc_loc_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.InstrValid) begin
                        op_q        <= bus.Opcode;
                        use_imm_q   <= bus.UseImm;
                        imm_q       <= bus.Imm;
                        rdest_loc_q <= bus.Dest;
                        rsrc_loc_q  <= bus.Src;
                        ready_q     <= 1'b0;
                        state_q     <= StRead;
                    end
                end
                StRead: begin
                    a_q     <= bus.RdestOut;
                    b_q     <= b_sel;
                    state_q <= StExec;
                end
                StExec: begin
                    result_q     <= alu_result;
                    flags_pend_q <= flags_nxt;
                    rf_en_q      <= !alu_illegal && (op_q != OpCmp);
                    done_q       <= 1'b1;
                    illegal_q    <= alu_illegal && is_reserved(op_q);
                    state_q      <= StWrite;
                end
                StWrite: begin
                    rf_en_q   <= 1'b0;
                    done_q    <= 1'b0;
                    illegal_q <= 1'b0;
                    flags_q   <= flags_pend_q;
                    ready_q   <= 1'b1;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.InstrReady  = ready_q;
    assign bus.RdestRegLoc = rdest_loc_q;
    assign bus.RsrcRegLoc  = rsrc_loc_q;
    assign bus.RfEn        = rf_en_q;
    assign bus.RfLoad      = result_q;
    assign Flags           = flags_q;
    assign Done            = done_q;
    assign IllegalOp       = illegal_q;

endmodule

// File: tb/tb_regfile_exec_ctrl.sv
// Testbench for regfile_exec_ctrl: a behavioural register file on the slave
// side, a reference model that pushes expected results into a scoreboard at
// issue time, and directed steps that pop and compare on Done.
module tb_regfile_exec_ctrl;
    import regfile_exec_ctrl_pkg::*;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic [3:0] Flags;
    logic       Done;
    logic       IllegalOp;

    always #5 Clk = ~Clk;

    regfile_exec_ctrl_if bus ();

    regfile_exec_ctrl dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .bus       (bus),
        .Flags     (Flags),
        .Done      (Done),
        .IllegalOp (IllegalOp)
    );

    // Register file with a bench-only preload port
    logic [15:0] rf [16];
    logic        pre_we = 1'b0;
    logic [3:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;
    int unsigned rf_writes = 0;

    always @(posedge Clk) begin
        if (pre_we) begin
            rf[pre_addr] <= pre_data;
        end else if (bus.RfEn) begin
            rf[bus.RdestRegLoc] <= bus.RfLoad;
            rf_writes <= rf_writes + 1;
        end
    end

    assign bus.RdestOut = rf[bus.RdestRegLoc];
    assign bus.RsrcOut  = rf[bus.RsrcRegLoc];

    typedef struct {
        logic        wr;
        logic [3:0]  dest;
        logic [15:0] data;
        logic [3:0]  flags;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mrf [16];
    logic [3:0]  mflags = 4'b0000;
    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: integer arithmetic, flags as {C,F,Z,N}
    task automatic push_exp(input logic [3:0] op, input logic ui, input logic [3:0] d,
                            input logic [3:0] s, input logic [7:0] imm);
        exp_t        e;
        logic [15:0] a, b, res;
        int          ua, ub, sa, sb_i, sr, tmp;
        longint      r;
        a   = mrf[d];
        tmp = $signed(imm);
        b   = ui ? tmp[15:0] : mrf[s];
        ua  = int'(a);
        ub  = int'(b);
        sa  = $signed(a);
        sb_i = $signed(b);
        e.flags = mflags;
        e.wr    = 1'b1;
        e.ill   = 1'b0;
        e.dest  = d;
        res     = '0;
        case (op)
            4'd0: begin
                r = ua + ub; res = r[15:0]; sr = sa + sb_i;
                e.flags = {r > 65535, (sr > 32767) || (sr < -32768), res == 0, res[15]};
            end
            4'd1, 4'd6: begin
                r = ua - ub; res = r[15:0]; sr = sa - sb_i;
                e.flags = {ua < ub, (sr > 32767) || (sr < -32768), res == 0, res[15]};
                if (op == 4'd6) e.wr = 1'b0;
            end
            4'd2, 4'd3, 4'd4, 4'd7: begin
                if (op == 4'd2) res = a & b;
                else if (op == 4'd3) res = a | b;
                else if (op == 4'd4) res = a ^ b;
                else begin
                    r = longint'(ua) * (longint'(1) << (ub % 16));
                    res = r[15:0];
                end
                e.flags[1] = (res == 0);
                e.flags[0] = res[15];
            end
            4'd5: res = b;
            default: begin
                e.wr  = 1'b0;
                e.ill = 1'b1;
            end
        endcase
        e.data = res;
        if (e.wr) mrf[d] = res;
        mflags = e.flags;
        sb.push_back(e);
    endtask

    task automatic preload(input logic [3:0] a, input logic [15:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge Clk);
        pre_we   = 1'b0;
        mrf[a]   = d;
    endtask

    task automatic drive(input logic [3:0] op, input logic ui, input logic [3:0] d,
                         input logic [3:0] s, input logic [7:0] imm);
        bus.Opcode = op;
        bus.UseImm = ui;
        bus.Dest   = d;
        bus.Src    = s;
        bus.Imm    = imm;
    endtask

    task automatic check_retire(input string tag);
        exp_t e;
        e = sb.pop_front();
        chk({tag, " RfEn"}, bus.RfEn, e.wr);
        chk({tag, " IllegalOp"}, IllegalOp, e.ill);
        chk({tag, " dest"}, bus.RdestRegLoc, e.dest);
        if (e.wr) chk({tag, " RfLoad"}, bus.RfLoad, e.data);
    endtask

    // One instruction: handshake, latency, retire, flags and idle state
    task automatic issue(input string tag, input logic [3:0] op, input logic ui,
                         input logic [3:0] d, input logic [3:0] s, input logic [7:0] imm);
        int          lat;
        int unsigned w0;
        logic [3:0]  exp_flags;
        logic        exp_wr;
        w0 = rf_writes;
        chk({tag, " ready"}, bus.InstrReady, 1);
        push_exp(op, ui, d, s, imm);
        exp_flags = sb[$].flags;
        exp_wr    = sb[$].wr;
        drive(op, ui, d, s, imm);
        bus.InstrValid = 1'b1;
        @(negedge Clk);
        bus.InstrValid = 1'b0;
        chk({tag, " ready low"}, bus.InstrReady, 0);
        chk({tag, " src loc"}, bus.RsrcRegLoc, s);
        lat = 1;
        while (!Done && lat < 8) begin
            @(negedge Clk);
            lat++;
        end
        chk({tag, " latency"}, lat, 3);
        if (Done) begin
            check_retire(tag);
            @(negedge Clk);
            chk({tag, " done low"}, Done, 0);
            chk({tag, " flags"}, Flags, exp_flags);
            chk({tag, " ready again"}, bus.InstrReady, 1);
            chk({tag, " writes"}, rf_writes, w0 + (exp_wr ? 1 : 0));
            chk({tag, " dest hold"}, bus.RdestRegLoc, d);
        end else begin
            void'(sb.pop_back());
        end
    endtask

    int          acc_cyc [3];
    int          n_acc, cyc, done_cnt, ready_hi;
    logic        just_acc;
    int unsigned w_save;

    initial begin
        bus.InstrValid = 1'b0;
        drive(4'd0, 1'b0, 4'd0, 4'd0, 8'd0);
        for (int i = 0; i < 16; i++) mrf[i] = '0;

        // Reset held for two edges
        repeat (2) @(negedge Clk);
        chk("rst RfEn", bus.RfEn, 0);
        chk("rst Done", Done, 0);
        chk("rst Flags", Flags, 0);
        chk("rst ready", bus.InstrReady, 1);
        chk("rst IllegalOp", IllegalOp, 0);
        chk("rst dest loc", bus.RdestRegLoc, 0);
        Rst = 1'b1;
        @(negedge Clk);

        preload(4'd1, 16'h7FFF);
        preload(4'd2, 16'h0001);
        preload(4'd4, 16'h0005);
        preload(4'd7, 16'h0000);

        issue("add", OpAdd, 1'b0, 4'd1, 4'd2, 8'h00);
        chk("add R1", rf[1], 16'h8000);
        chk("add flags const", Flags, 4'b0101);

        // Abort in EXEC: no write, flags cleared
        preload(4'd3, 16'h1234);
        w_save = rf_writes;
        drive(OpAdd, 1'b0, 4'd3, 4'd3, 8'h00);
        bus.InstrValid = 1'b1;
        @(negedge Clk);
        bus.InstrValid = 1'b0;
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        chk("abort ready", bus.InstrReady, 1);
        chk("abort RfEn", bus.RfEn, 0);
        chk("abort Done", Done, 0);
        chk("abort Flags", Flags, 0);
        Rst = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        chk("abort R3", rf[3], 16'h1234);
        chk("abort writes", rf_writes, w_save);
        mflags = 4'b0000;

        issue("sub", OpSub, 1'b1, 4'd4, 4'd0, 8'h06);
        chk("sub R4", rf[4], 16'hFFFF);
        chk("sub flags const", Flags, 4'b1001);

        issue("cmp", OpCmp, 1'b1, 4'd4, 4'd0, 8'hFF);
        chk("cmp flags const", Flags, 4'b0010);
        chk("cmp R4", rf[4], 16'hFFFF);

        issue("mov", OpMov, 1'b1, 4'd7, 4'd0, 8'h80);
        chk("mov R7", rf[7], 16'hFF80);
        chk("mov flags const", Flags, 4'b0010);

        preload(4'd2, 16'h0004);
        issue("lsh", OpLsh, 1'b0, 4'd7, 4'd2, 8'h00);
        chk("lsh R7", rf[7], 16'hF800);
        chk("lsh flags const", Flags, 4'b0001);

        issue("illegal", 4'hA, 1'b0, 4'd5, 4'd6, 8'h00);
        chk("illegal flags const", Flags, 4'b0001);

        // Three dependent ADDs with InstrValid held high throughout
        preload(4'd1, 16'h0000);
        preload(4'd2, 16'h0001);
        drive(OpAdd, 1'b0, 4'd1, 4'd2, 8'h00);
        bus.InstrValid = 1'b1;
        n_acc    = 0;
        cyc      = 0;
        done_cnt = 0;
        ready_hi = 0;
        while (done_cnt < 3 && cyc < 40) begin
            just_acc = 1'b0;
            if (bus.InstrReady) begin
                ready_hi++;
                if (bus.InstrValid && n_acc < 3) begin
                    acc_cyc[n_acc] = cyc;
                    push_exp(OpAdd, 1'b0, 4'd1, 4'd2, 8'h00);
                    n_acc++;
                    just_acc = 1'b1;
                end
            end
            if (Done) begin
                check_retire("b2b");
                done_cnt++;
            end
            @(negedge Clk);
            cyc++;
            if (just_acc && n_acc == 3) bus.InstrValid = 1'b0;
        end
        chk("b2b retired", done_cnt, 3);
        chk("b2b ready cycles", ready_hi, 3);
        chk("b2b spacing 1", acc_cyc[1] - acc_cyc[0], 4);
        chk("b2b spacing 2", acc_cyc[2] - acc_cyc[1], 4);
        chk("b2b R1", rf[1], 16'h0003);
        chk("b2b flags", Flags, mflags);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/regfile_exec_ctrl.md
Name: regfile_exec_ctrl

Overview:
- Initiator side of the 16x16 register-file port: accepts one decoded instruction per handshake and reads Rdest/Rsrc through the two read ports.
- Executes a 16-bit ALU op, then writes the result back through the single write port (En/Load, addressed by RdestRegLoc).
- Holds the processor status flags.
- Sits between instruction decode and the register file; it is the only driver of the register file's address, enable and load inputs.

Parameters:
- DATA_W, 16, operand/result width (must match register file).
- ADDR_W, 4, register index width (16 registers).
- IMM_W, 8, immediate width; sign-extended to DATA_W.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  reset, synchronous, active-low.
- InstrValid  in  1  instruction present.
- InstrReady  out  1  block can accept.
- Opcode  in  4  operation code.
- UseImm  in  1  1 = operand B is sign-extended Imm, 0 = Rsrc register.
- Dest  in  ADDR_W  destination/operand A register.
- Src  in  ADDR_W  source register.
- Imm  in  IMM_W  immediate.
- RdestRegLoc  out  ADDR_W  register file dest/write address.
- RsrcRegLoc  out  ADDR_W  register file source address.
- RdestOut  in  DATA_W  register file dest read data (combinational).
- RsrcOut  in  DATA_W  register file source read data (combinational).
- RfEn  out  1  register file write enable.
- RfLoad  out  DATA_W  write data.
- Flags  out  4  {C,F,Z,N} status.
- Done  out  1  one-cycle pulse, instruction retired.
- IllegalOp  out  1  one-cycle pulse with Done for reserved opcode.

Behaviour:
- Reset (Rst=0 at rising edge):
  - state=IDLE; all outputs 0 except InstrReady=1.
  - Internal operand/result registers cleared.
  - Reset mid-instruction aborts it: no write, no Done, flags cleared.
- FSM states: IDLE, READ, EXEC, WRITE.
- IDLE:
  - InstrReady=1.
  - On InstrValid=1 at an edge: latch Opcode, UseImm, Dest, Src, Imm; go to READ.
- READ:
  - InstrReady=0; RdestRegLoc=Dest, RsrcRegLoc=Src.
  - At the edge: A<=RdestOut; B<=UseImm ? sext(Imm) : RsrcOut. Go to EXEC.
- EXEC: result and flags computed from A,B and registered at the edge; go to WRITE.
- WRITE:
  - RdestRegLoc=Dest, RfLoad=result, RfEn=1 unless opcode is CMP or reserved.
  - Done=1; flags update at this edge; go to IDLE.
- Latency and throughput:
  - Handshake at edge T0 → register written at edge T3; Done high during cycle T2–T3.
  - Next accept possible at edge T4 (one instruction per 4 cycles).
- Address outputs hold their last values while IDLE. RfEn is 0 in every state except WRITE.
- InstrValid while InstrReady=0 is ignored; the producer holds the instruction until the handshake.
- Opcodes:
  - 0 ADD: A+B.
  - 1 SUB: A−B.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 MOV: B.
  - 6 CMP: A−B, no write.
  - 7 LSH: A<<B[3:0], zero fill.
  - 8–15 reserved: no write, flags unchanged, IllegalOp=1 with Done.
- Arithmetic: 17-bit internally; result truncated to 16 bits.
- Flags:
  - ADD: C=carry out; F=signed overflow; Z=(result==0); N=result[15].
  - SUB/CMP: C=1 when A<B unsigned (borrow); F=signed overflow; Z and N as above.
  - AND/OR/XOR/LSH: update Z,N only; C,F hold.
  - MOV: flags hold.
- Dest==Src is legal: both operands read the same register; the write lands at T3.
- Back-to-back dependency needs no forwarding: READ of instruction n+1 occurs after edge T3 of instruction n.

Decomposition:
- Shared package: opcode constants, FSM state encoding, flag bit indices (C=3, F=2, Z=1, N=0), DATA_W/ADDR_W defaults. The register file and decode will reuse these.
- One sub-module alu16: combinational. Inputs A, B, Opcode. Outputs result, carry, ovf, illegal.

Test Plan:
- Reset with Rst=0 for 2 cycles → RfEn=0, Done=0, Flags=0000, InstrReady=1. Mid-instruction reset in EXEC → no write, R3 unchanged.
- Preload R1=0x7FFF, R2=0x0001; ADD Dest=1 Src=2 → R1=0x8000 written at T3, Flags C=0 F=1 Z=0 N=1, Done at T2 only.
- R4=0x0005; SUB Dest=4 with UseImm=1, Imm=0x06 → R4=0xFFFF, C=1 N=1 Z=0 F=0. CMP R4 vs Imm 0xFF → RfEn never 1, Z=1.
- MOV Dest=7 with UseImm=1, Imm=0x80 → R7=0xFF80, flags unchanged. LSH R7 by Src R2=0x0004 → R7=0xF800, Z=0 N=1.
- Opcode 0xA → Done and IllegalOp pulse together, no RfEn, flags held.
- InstrValid held continuously with 3 dependent ADDs (R1+=R2, R2=1, R1=0) → R1=3; accepts exactly 4 cycles apart; InstrReady=0 in READ/EXEC/WRITE.
